// File: rtl/piso_tx_scheduler_if.sv
// Request/serial-link bundle for piso_tx_scheduler.
// The scheduler sits on the slave modport; the requesters and link consumer use master.
interface piso_tx_scheduler_if #(
    parameter int unsigned WIDTH = 4
);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_ready;
    logic             stall;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             sout_owner;
    logic             busy;

    modport master (
        output req_valid,
        output req_data0,
        output req_data1,
        output stall,
        input  req_ready,
        input  sout,
        input  sout_valid,
        input  sout_first,
        input  sout_last,
        input  sout_owner,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data0,
        input  req_data1,
        input  stall,
        output req_ready,
        output sout,
        output sout_valid,
        output sout_first,
        output sout_last,
        output sout_owner,
        output busy
    );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Two-requester round-robin PISO serializer: loads a granted word, shifts it out LSB-first.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_scheduler #(
    parameter int unsigned WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    piso_tx_scheduler_if.slave     tx
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    // Single requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = 1'b0;
        unique case (tx.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_q;
            default: grant = 1'b0;
        endcase
    end

    assign accept     = rst_n && (state_q == StIdle) && (|tx.req_valid);
    assign grant_data = grant ? tx.req_data1 : tx.req_data0;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d  = grant_data;
                    owner_d  = grant;
                    cnt_d    = '0;
                    rr_d     = ~grant;
                    state_d  = StShift;
`ifdef PISO_TX_PARITY_EN
                    parity_d = ^grant_data;
`endif
                end
            end
            StShift: begin
                if (!tx.stall) begin
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                if (!tx.stall) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Link outputs come from registered state only; stall gates the qualifiers.
    always_comb begin
        tx.req_ready  = 2'b00;
        tx.sout       = 1'b0;
        tx.sout_valid = 1'b0;
        tx.sout_first = 1'b0;
        tx.sout_last  = 1'b0;
        tx.sout_owner = owner_q;
        tx.busy       = (state_q != StIdle);

        if (accept) begin
            tx.req_ready = grant ? 2'b10 : 2'b01;
        end

        unique case (state_q)
            StShift: begin
                tx.sout       = shreg_q[0];
                tx.sout_valid = ~tx.stall;
                tx.sout_first = ~tx.stall & (cnt_q == '0);
`ifndef PISO_TX_PARITY_EN
                tx.sout_last  = ~tx.stall & (cnt_q == CntLast);
`endif
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                tx.sout       = parity_q;
                tx.sout_valid = ~tx.stall;
                tx.sout_last  = ~tx.stall;
            end
`endif
            default: ;
        endcase
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(tx.req_ready));
    a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        (tx.req_ready != 2'b00) |-> !tx.busy);
    a_valid_in_frame: assert property (@(posedge clk) disable iff (!rst_n)
        tx.sout_valid |-> tx.busy);

endmodule

// File: doc/piso_tx_scheduler.md
# piso_tx_scheduler

Sequencing controller around a 4-bit parallel-in/serial-out shifter that shares one serial line between two requesters. The block arbitrates round-robin between the two parallel word sources, loads the granted word, and shifts it out LSB-first as a framed bit stream. It drives the serial link and reports frame boundaries and ownership. The shift register is internal, so the block is the only driver of the serial line.

## Interface
- WIDTH, 4, data bits per word (2..16)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  2  per-requester word valid; bit i belongs to requester i
- req_data0  input  WIDTH  requester 0 parallel word
- req_data1  input  WIDTH  requester 1 parallel word
- req_ready  output  2  one-hot accept pulse; word taken on the clk edge where valid&ready
- stall  input  1  freezes shifting while high
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit this cycle
- sout_first  output  1  first bit of frame
- sout_last  output  1  last bit of frame
- sout_owner  output  1  requester index of current frame
- busy  output  1  frame in progress (state != IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY only with macro enabled).
- IDLE: if any req_valid, grant = round-robin winner; req_ready[grant]=1 combinationally (only in IDLE, never while rst_n low). On that edge: shreg <= granted data, owner <= grant, cnt <= 0, parity_acc <= ^data, state -> SHIFT, rr pointer <= ~grant.
- Round-robin: pointer resets to 0 (requester 0 favoured). Single valid requester always wins regardless of pointer. Both valid: pointer selects; after each grant pointer moves to the other requester.
- SHIFT: sout = shreg[0]. If stall=0: shreg shifts right (MSB zero-filled), cnt++. When cnt==WIDTH-1 and stall=0: next state PARITY if enabled else IDLE.
- PARITY: sout = parity bit; stall=0 -> IDLE; stall=1 holds.
- sout_valid = 1 in SHIFT/PARITY when stall=0; 0 otherwise. During stall sout/owner/shreg/cnt hold.
- sout_first = sout_valid & (state==SHIFT) & cnt==0. sout_last = sout_valid on final frame bit (cnt==WIDTH-1 without parity, PARITY state with parity).
- stall in IDLE has no effect on arbitration; a word may be accepted while stall=1, shifting starts when stall drops.
- req_valid changes outside IDLE are ignored; no accept while busy.
- Reset (async, any state, mid-frame included): state IDLE, shreg 0, cnt 0, owner 0, rr pointer 0; partial frame discarded, no completion signalled.
- Reset values: req_ready 0, sout 0, sout_valid 0, sout_first 0, sout_last 0, sout_owner 0, busy 0.

## Timing
- Accept cycle A (IDLE, ready high). First bit on sout at A+1; bit k at A+1+k with no stall.
- Frame length: WIDTH cycles, WIDTH+1 with parity. Each stalled cycle adds one cycle.
- Return to IDLE one cycle after last bit; next accept earliest the cycle after sout_last. Min period WIDTH+1 (WIDTH+2 with parity), i.e. one idle gap cycle between frames.
- sout, sout_valid, sout_first, sout_last, sout_owner, busy derive only from registered state (no combinational path from req_* inputs); req_ready depends combinationally on req_valid and state; sout_valid/first/last also gated combinationally by stall.

## Configuration
- PISO_TX_PARITY_EN defined: PARITY state compiled in; one extra frame bit after data, value = XOR of the WIDTH data bits (even parity: total ones incl. parity is even); sout_last on the parity bit.
- Undefined: no PARITY state, no parity register; frame is exactly WIDTH bits, sout_last on data bit WIDTH-1.

## Test plan
- Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, all outputs 0; release -> requester 0 granted first.
- Single word: req_valid=01, req_data0=4'b1011 -> ready[0] for one cycle, sout=1,1,0,1 at A+1..A+4, first at A+1, last at A+4 (parity build: extra bit 1, last at A+5), owner 0.
- Contention: both valid continuously, data0=4'h3, data1=4'hC -> frames alternate owner 0,1,0,1; one idle cycle between frames; each word accepted exactly once per grant.
- Stall: assert stall 2 cycles after bit 1 of 4'b0100 -> sout holds, sout_valid=0 for those cycles, sequence still 0,0,1,0, frame lengthened by 2.
- Reset mid-frame: drop rst_n after bit 2 of requester 1 frame -> outputs 0 immediately (async); after release, next frame from requester 0 starts clean at bit 0.
- Parity (macro on): word 4'b0111 -> parity bit 1; word 4'b0000 -> parity bit 0; macro off -> no 5th bit.
